// File: rtl/image_pkg.sv
// rtl/image_pkg.sv - shared constants, colour type and clear-sequencer states
package image_pkg;

  localparam int DEPTH = 49152;
  localparam int AW    = $clog2(DEPTH);
  localparam int DW    = 8;

  typedef logic [DW-1:0] col8bit_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } state_e;

endpackage

// File: rtl/image_clear_seq.sv
// rtl/image_clear_seq.sv - frame-clear sequencer: walks every cell writing one colour
module image_clear_seq
  import image_pkg::*;
#(
  parameter int DEPTH = image_pkg::DEPTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  col8bit_t      col_i,
  input  logic          slot_free_i,
  output state_e        state_o,
  output logic [AW-1:0] cnt_o,
  output col8bit_t      col_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  col8bit_t      col_q, col_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
    end
  end

  // The counter only advances on cycles where the display left the port free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          col_d   = col_i;
        end
      end
      S_CLEAR: begin
        if (slot_free_i) begin
          if (cnt_q == LAST_ADDR) begin
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign col_o   = col_q;
  assign busy_o  = (state_q == S_CLEAR);
  assign done_o  = (state_q == S_DONE);

endmodule

// File: rtl/image_port_arbiter.sv
// rtl/image_port_arbiter.sv - shares the image RAM port: display > frame clear > host
module image_port_arbiter
  import image_pkg::*;
#(
  parameter int DEPTH = image_pkg::DEPTH
) (
  input  logic          iclk,
  input  logic          irst_n,
  input  logic          idisp_rd_en,
  input  logic [AW-1:0] idisp_addr,
  output logic [DW-1:0] odisp_col8bit,
  output logic          odisp_vld,
  input  logic          ihost_valid,
  output logic          ohost_ready,
  input  logic [AW-1:0] ihost_addr,
  input  logic [DW-1:0] ihost_data,
  output logic          ohost_err,
  input  logic          iclr_start,
  input  logic [DW-1:0] iclr_col8bit,
  output logic          oclr_busy,
  output logic          oclr_done,
  output logic [AW-1:0] omem_addr,
  output logic          omem_rd_en,
  output logic          omem_wr_en,
  output logic [DW-1:0] omem_wdata,
  input  logic [DW-1:0] imem_rdata
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        clr_state;
  logic [AW-1:0] clr_cnt;
  col8bit_t      clr_col;
  logic          host_fire;
  logic          host_addr_ok;
  logic          disp_vld_q, disp_vld_d;
  logic          host_err_q, host_err_d;

  image_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk_i       (iclk),
    .rst_ni      (irst_n),
    .start_i     (iclr_start),
    .col_i       (iclr_col8bit),
    .slot_free_i (!idisp_rd_en),
    .state_o     (clr_state),
    .cnt_o       (clr_cnt),
    .col_o       (clr_col),
    .busy_o      (oclr_busy),
    .done_o      (oclr_done)
  );

  assign ohost_ready  = (clr_state == S_IDLE) && !idisp_rd_en;
  assign host_fire    = ihost_valid && ohost_ready;
  assign host_addr_ok = (ihost_addr <= LAST_ADDR);

  // Out-of-range host writes are still handshaken so the host never hangs.
  always_comb begin
    omem_addr  = '0;
    omem_rd_en = 1'b0;
    omem_wr_en = 1'b0;
    omem_wdata = '0;
    if (idisp_rd_en) begin
      omem_addr  = idisp_addr;
      omem_rd_en = 1'b1;
    end else if (clr_state == S_CLEAR) begin
      omem_addr  = clr_cnt;
      omem_wr_en = 1'b1;
      omem_wdata = clr_col;
    end else if (host_fire) begin
      omem_addr  = ihost_addr;
      omem_wdata = ihost_data;
      omem_wr_en = host_addr_ok;
    end
  end

  assign disp_vld_d = idisp_rd_en;
  assign host_err_d = host_fire && !host_addr_ok;

  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      disp_vld_q <= 1'b0;
      host_err_q <= 1'b0;
    end else begin
      disp_vld_q <= disp_vld_d;
      host_err_q <= host_err_d;
    end
  end

  assign odisp_vld     = disp_vld_q;
  assign ohost_err     = host_err_q;
  assign odisp_col8bit = imem_rdata;

endmodule

// File: tb/tb_image_port_arbiter.sv
// tb/tb_image_port_arbiter.sv - randomized and directed bench for image_port_arbiter
module tb_image_port_arbiter;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd;
  logic [15:0] da;
  logic        hv;
  logic [15:0] ha;
  logic [7:0]  hd;
  logic        cs;
  logic [7:0]  cc;

  logic [7:0]  disp_col;
  logic        disp_vld;
  logic        host_ready;
  logic        host_err;
  logic        clr_busy;
  logic        clr_done;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  logic [7:0]  img [0:65535];

  int vectors = 0;
  int miscompares = 0;

  int       m_q[$];
  logic [7:0] m_col;
  logic     m_done;
  logic     m_vld;
  logic     m_err;
  logic [7:0] m_rdata;

  always #5 clk = ~clk;

  image_port_arbiter #(.DEPTH(DEPTH)) dut (
    .iclk          (clk),
    .irst_n        (rst_n),
    .idisp_rd_en   (rd),
    .idisp_addr    (da),
    .odisp_col8bit (disp_col),
    .odisp_vld     (disp_vld),
    .ihost_valid   (hv),
    .ohost_ready   (host_ready),
    .ihost_addr    (ha),
    .ihost_data    (hd),
    .ohost_err     (host_err),
    .iclr_start    (cs),
    .iclr_col8bit  (cc),
    .oclr_busy     (clr_busy),
    .oclr_done     (clr_done),
    .omem_addr     (mem_addr),
    .omem_rd_en    (mem_rd_en),
    .omem_wr_en    (mem_wr_en),
    .omem_wdata    (mem_wdata),
    .imem_rdata    (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_done = 1'b0;
    m_vld  = 1'b0;
    m_err  = 1'b0;
    m_col  = 8'h00;
  endtask

  // One clock: check outputs at the falling edge, then advance the reference model.
  task automatic step();
    logic e_ready, e_rd, e_wr, clearing;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    @(negedge clk);
    clearing = (m_q.size() > 0);
    e_ready  = !clearing && !m_done && !rd;
    e_rd = 1'b0; e_wr = 1'b0; e_addr = 16'h0; e_wd = 8'h0;
    if (rd) begin
      e_rd = 1'b1; e_addr = da;
    end else if (clearing) begin
      e_wr = 1'b1; e_addr = 16'(m_q[0]); e_wd = m_col;
    end else if (hv && e_ready) begin
      e_addr = ha; e_wd = hd; e_wr = (ha < DEPTH);
    end
    chk("host_ready", 32'(host_ready), 32'(e_ready));
    chk("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    chk("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_wr) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    chk("disp_vld", 32'(disp_vld), 32'(m_vld));
    if (m_vld) chk("disp_col", 32'(disp_col), 32'(m_rdata));
    chk("host_err", 32'(host_err), 32'(m_err));
    chk("clr_busy", 32'(clr_busy), 32'(clearing));
    chk("clr_done", 32'(clr_done), 32'(m_done));
    if (rd) m_rdata = img[da];
    if (e_wr) img[e_addr] = e_wd;
    if (!rst_n) begin
      model_reset();
    end else begin
      m_vld = rd;
      m_err = hv && e_ready && (ha >= DEPTH);
      if (m_done) begin
        m_done = 1'b0;
      end else if (clearing) begin
        if (!rd) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_done = 1'b1;
        end
      end else if (cs) begin
        for (int i = 0; i < DEPTH; i++) m_q.push_back(i);
        m_col = cc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd = 1'b0; da = 16'h0; hv = 1'b0; ha = 16'h0; hd = 8'h0; cs = 1'b0; cc = 8'h0;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 8'h00;
      img[i] = 8'h00;
    end
    mem_rdata = 8'h00;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    step();

    // Display has priority over a waiting host
    rd = 1'b1; da = 16'h0123; hv = 1'b1; ha = 16'h0009; hd = 8'h5A;
    step();
    rd = 1'b0;
    step();
    hv = 1'b0;
    step();

    // Plain host write
    hv = 1'b1; ha = 16'h0005; hd = 8'hA5;
    step();
    hv = 1'b0;
    step();

    // Out-of-range host address
    hv = 1'b1; ha = 16'd49152; hd = 8'hFF;
    step();
    hv = 1'b0;
    repeat (2) step();

    // Full clear with the display stealing about half the cycles
    cs = 1'b1; cc = 8'h3C; hv = 1'b1; ha = 16'h0002; hd = 8'h11;
    step();
    cs = 1'b0;
    for (int n = 0; n < 60; n++) begin
      rd = 1'($urandom_range(0, 1));
      da = 16'($urandom_range(0, DEPTH - 1));
      step();
    end
    hv = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      rd = 1'b1; da = 16'(i);
      step();
    end
    rd = 1'b0;
    step();

    // Clear start coincident with a host write; second start ignored
    cs = 1'b1; cc = 8'h77; hv = 1'b1; ha = 16'h0007; hd = 8'hC3;
    step();
    hv = 1'b0; cs = 1'b0;
    repeat (4) step();
    cs = 1'b1; cc = 8'h99;
    step();
    cs = 1'b0;
    repeat (DEPTH) step();

    // Reset in the middle of a clear, then restart
    cs = 1'b1; cc = 8'hE1;
    step();
    cs = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    hv = 1'b1; ha = 16'h0003; hd = 8'h42;
    step();
    hv = 1'b0; cs = 1'b1; cc = 8'h0F;
    step();
    cs = 1'b0;
    repeat (DEPTH + 3) step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rd    = 1'($urandom_range(0, 1));
      da    = 16'($urandom_range(0, 2 * DEPTH - 1));
      hv    = ($urandom_range(0, 9) < 6);
      ha    = 16'($urandom_range(0, 2 * DEPTH - 1));
      hd    = 8'($urandom);
      cs    = ($urandom_range(0, 19) == 0);
      cc    = 8'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
